// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_AW   = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [3:0]        opcode_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HAZARD  = 2'd1,
    MEMWAIT = 2'd2,
    FLUSH   = 2'd3
  } stall_cause_t;

  // Nearest producer wins: EX_MEM result takes precedence over MEM_WB.
  function automatic fwd_sel_t fwd_select(
    input logic      use_rs,
    input reg_addr_t rs,
    input logic      ex_ok,
    input reg_addr_t ex_rd,
    input logic      mem_ok,
    input reg_addr_t mem_rd
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_rs && ex_ok && (ex_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (use_rs && mem_ok && (mem_rd == rs)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-writer counts and RAW hazard detection for the ID stage.
module hazard_scoreboard
  import pipeline_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      id_valid,
  input  logic      use_rs1,
  input  logic      use_rs2,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  logic      inc_en,
  input  reg_addr_t inc_rd,
  input  logic      dec_en,
  input  reg_addr_t dec_rd,
  output logic      hazard
);

  logic [1:0]          pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    if (inc_en) inc_hit[inc_rd] = 1'b1;
    if (dec_en) dec_hit[dec_rd] = 1'b1;
  end

  // Simultaneous issue and retire on one register cancel out; counts saturate.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!rst_n) begin
        pend[i] <= '0;
      end else if (inc_hit[i] && !dec_hit[i] && (pend[i] != 2'd3)) begin
        pend[i] <= pend[i] + 2'd1;
      end else if (dec_hit[i] && !inc_hit[i] && (pend[i] != 2'd0)) begin
        pend[i] <= pend[i] - 2'd1;
      end
    end
  end

  assign hazard = id_valid &
                  ((use_rs1 & (pend[rs1] != 2'd0)) |
                   (use_rs2 & (pend[rs2] != 2'd0)));

  sb_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !((inc_en && !(dec_en && (dec_rd == inc_rd)) && (pend[inc_rd] == 2'd3)) ||
      (dec_en && !(inc_en && (inc_rd == dec_rd)) && (pend[dec_rd] == 2'd0))));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stage enable / flush / bubble / forwarding control for the 5-stage pipeline.
// Build option: PIPELINE_FORWARDING_EN selects forwarding instead of the scoreboard.
module pipeline_hazard_controller
  import pipeline_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        id_valid,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_wr_rd,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic [3:0]  id_rd,
  input  logic        ex_valid,
  input  logic        ex_wr_rd,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_rd,
  input  logic        mem_valid,
  input  logic        mem_wr_rd,
  input  logic [3:0]  mem_rd,
  input  logic        wb_valid,
  input  logic        wb_wr_rd,
  input  logic [3:0]  wb_rd,
  input  logic        ex_jump_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        issue,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  stall_cause,
  output logic [15:0] stall_cnt
);

  logic         hazard;
  logic         mem_wait;
  fwd_sel_t     sel_a;
  fwd_sel_t     sel_b;
  stall_cause_t cause;
  stall_cause_t cause_q;
  fwd_sel_t     fwd_a_q;
  fwd_sel_t     fwd_b_q;
  logic [15:0]  cnt_q;

  assign mem_wait = mem_req & ~mem_ack;

`ifdef PIPELINE_FORWARDING_EN
  logic ex_fwd_ok;
  logic mem_fwd_ok;
  logic unused_sb_inputs;

  assign ex_fwd_ok  = ex_valid & ex_wr_rd & ~ex_is_load;
  assign mem_fwd_ok = mem_valid & mem_wr_rd;
  // A load result only exists after MEM, so a load-use pair costs one stall.
  assign hazard = id_valid & ex_valid & ex_is_load & ex_wr_rd &
                  ((id_use_rs1 & (ex_rd == id_rs1)) |
                   (id_use_rs2 & (ex_rd == id_rs2)));
  assign sel_a  = fwd_select(id_use_rs1, id_rs1, ex_fwd_ok, ex_rd, mem_fwd_ok, mem_rd);
  assign sel_b  = fwd_select(id_use_rs2, id_rs2, ex_fwd_ok, ex_rd, mem_fwd_ok, mem_rd);
  assign unused_sb_inputs = ^{id_wr_rd, id_rd, wb_valid, wb_wr_rd, wb_rd};
`else
  logic unused_fwd_inputs;

  hazard_scoreboard u_scoreboard (
    .clk      (Clock),
    .rst_n    (Reset),
    .id_valid (id_valid),
    .use_rs1  (id_use_rs1),
    .use_rs2  (id_use_rs2),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .inc_en   (issue & id_wr_rd),
    .inc_rd   (id_rd),
    .dec_en   (wb_valid & wb_wr_rd),
    .dec_rd   (wb_rd),
    .hazard   (hazard)
  );

  assign sel_a = FWD_RF;
  assign sel_b = FWD_RF;
  assign unused_fwd_inputs = ^{ex_valid, ex_wr_rd, ex_is_load, ex_rd,
                               mem_valid, mem_wr_rd, mem_rd};
`endif

  always_comb begin
    cause        = RUN;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    issue        = 1'b0;
    if (!Reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_wait) begin
      cause     = MEMWAIT;
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_jump_taken) begin
      cause        = FLUSH;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hazard) begin
      cause        = HAZARD;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cause_q <= RUN;
      cnt_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      cause_q <= cause;
      if ((cause != RUN) && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
      // ID_EX is frozen during a memory wait, so its operand selects are too.
      if (cause != MEMWAIT) begin
        fwd_a_q <= issue ? sel_a : FWD_RF;
        fwd_b_q <= issue ? sel_b : FWD_RF;
      end
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_cause = cause_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed, table-driven check of pipeline_hazard_controller (either build).
module tb_pipeline_hazard_controller;
  import pipeline_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        id_valid, id_use_rs1, id_use_rs2, id_wr_rd;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic        ex_valid, ex_wr_rd, ex_is_load;
  logic [3:0]  ex_rd;
  logic        mem_valid, mem_wr_rd;
  logic [3:0]  mem_rd;
  logic        wb_valid, wb_wr_rd;
  logic [3:0]  wb_rd;
  logic        ex_jump_taken, mem_req, mem_ack;
  logic        pc_en, if_id_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, issue;
  logic [1:0]  fwd_a, fwd_b, stall_cause;
  logic [15:0] stall_cnt;
  logic [6:0]  ctl;

  // {pc_en, if_id_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, issue}
  localparam logic [6:0] C_RUN_I = 7'b1111001;
  localparam logic [6:0] C_RUN   = 7'b1111000;
  localparam logic [6:0] C_FLUSH = 7'b1111110;
  localparam logic [6:0] C_MW    = 7'b0000000;
  localparam logic [6:0] C_HZ    = 7'b0011010;
  localparam logic [6:0] C_RST   = 7'b1111110;

  typedef struct {
    logic         idv;
    logic         use1;
    logic [3:0]   rs1;
    logic         jump;
    logic         mreq;
    logic         mack;
    logic [6:0]   ctl;
    stall_cause_t cause;
  } vec_t;

  vec_t        tbl [10];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt = 0;

  pipeline_hazard_controller dut (
    .Clock(Clock), .Reset(Reset),
    .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_wr_rd(id_wr_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_wr_rd(ex_wr_rd), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_wr_rd(wb_wr_rd), .wb_rd(wb_rd),
    .ex_jump_taken(ex_jump_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .issue(issue),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cause(stall_cause), .stall_cnt(stall_cnt)
  );

  assign ctl = {pc_en, if_id_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, issue};

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_wr_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    ex_valid = 0; ex_wr_rd = 0; ex_is_load = 0; ex_rd = 0;
    mem_valid = 0; mem_wr_rd = 0; mem_rd = 0;
    wb_valid = 0; wb_wr_rd = 0; wb_rd = 0;
    ex_jump_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  // Inputs are already applied (just after a rising edge); check this cycle.
  task automatic cycle(input string tag, input logic [6:0] c, input stall_cause_t cs);
    #1;
    chk({tag, " ctl"}, 32'(ctl), 32'(c));
    @(posedge Clock);
    #1;
    if (cs != RUN && exp_cnt < 32'hFFFF) exp_cnt++;
    chk({tag, " cause"}, 32'(stall_cause), 32'(cs));
    chk({tag, " cnt"}, 32'(stall_cnt), exp_cnt);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, C_RUN_I, RUN};
    tbl[1] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, C_RUN,   RUN};
    tbl[2] = '{1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, C_FLUSH, FLUSH};
    tbl[3] = '{1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, C_RUN_I, RUN};
    tbl[4] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, C_MW,    MEMWAIT};
    tbl[5] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, C_MW,    MEMWAIT};
    tbl[6] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, C_FLUSH, FLUSH};
    tbl[7] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, C_RUN_I, RUN};
    tbl[8] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, C_MW,    MEMWAIT};
    tbl[9] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, C_RUN_I, RUN};

    clr();
    Reset = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    chk("rst ctl", 32'(ctl), 32'(C_RST));
    chk("rst cause", 32'(stall_cause), 32'(RUN));
    chk("rst cnt", 32'(stall_cnt), 32'd0);
    chk("rst fwd", 32'({fwd_a, fwd_b}), 32'd0);
    Reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      clr();
      id_valid = tbl[i].idv; id_use_rs1 = tbl[i].use1; id_rs1 = tbl[i].rs1;
      ex_jump_taken = tbl[i].jump; mem_req = tbl[i].mreq; mem_ack = tbl[i].mack;
      cycle($sformatf("row%0d", i), tbl[i].ctl, tbl[i].cause);
    end

`ifndef PIPELINE_FORWARDING_EN
    // Scoreboard RAW on r3: three stall cycles, retire in the third, issue on the fourth.
    clr(); id_valid = 1; id_wr_rd = 1; id_rd = 3;
    cycle("raw prod", C_RUN_I, RUN);
    for (int k = 0; k < 3; k++) begin
      clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 3;
      wb_valid = (k == 2); wb_wr_rd = (k == 2); wb_rd = 3;
      cycle($sformatf("raw hz%0d", k), C_HZ, HAZARD);
    end
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 3;
    cycle("raw issue", C_RUN_I, RUN);
    chk("sb fwd", 32'({fwd_a, fwd_b}), 32'd0);

    // Same-cycle issue and retire on r7 leaves its count at 1.
    clr(); id_valid = 1; id_wr_rd = 1; id_rd = 7;
    cycle("r7 prod", C_RUN_I, RUN);
    clr(); id_valid = 1; id_wr_rd = 1; id_rd = 7; wb_valid = 1; wb_wr_rd = 1; wb_rd = 7;
    cycle("r7 same", C_RUN_I, RUN);
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 7; wb_valid = 1; wb_wr_rd = 1; wb_rd = 7;
    cycle("r7 hz", C_HZ, HAZARD);
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 7;
    cycle("r7 issue", C_RUN_I, RUN);

    // rs2 path on r4.
    clr(); id_valid = 1; id_wr_rd = 1; id_rd = 4;
    cycle("r4 prod", C_RUN_I, RUN);
    clr(); id_valid = 1; id_use_rs2 = 1; id_rs2 = 4; wb_valid = 1; wb_wr_rd = 1; wb_rd = 4;
    cycle("r4 hz", C_HZ, HAZARD);
    clr(); id_valid = 1; id_use_rs2 = 1; id_rs2 = 4;
    cycle("r4 issue", C_RUN_I, RUN);

    // Flush outranks hazard, then reset abandons the stall.
    clr(); id_valid = 1; id_wr_rd = 1; id_rd = 9;
    cycle("r9 prod", C_RUN_I, RUN);
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 9; ex_jump_taken = 1;
    cycle("r9 jump", C_FLUSH, FLUSH);
    ex_jump_taken = 0;
    cycle("r9 hz", C_HZ, HAZARD);
    Reset = 1'b0;
    #1;
    chk("mid rst ctl", 32'(ctl), 32'(C_RST));
    @(posedge Clock);
    #1;
    exp_cnt = 0;
    chk("mid rst cause", 32'(stall_cause), 32'(RUN));
    chk("mid rst cnt", 32'(stall_cnt), 32'd0);
    chk("mid rst fwd", 32'({fwd_a, fwd_b}), 32'd0);
    Reset = 1'b1;
    cycle("post rst issue", C_RUN_I, RUN);
`else
    // ADD writes r5 then a reader follows directly: EX_MEM forwarding.
    clr(); id_valid = 1; id_wr_rd = 1; id_rd = 5;
    cycle("fw prod", C_RUN_I, RUN);
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; ex_valid = 1; ex_wr_rd = 1; ex_rd = 5;
    cycle("fw ex", C_RUN_I, RUN);
    chk("fw ex fwd_a", 32'(fwd_a), 32'd1);
    chk("fw ex fwd_b", 32'(fwd_b), 32'd0);
    // One instruction in between: MEM_WB forwarding.
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; ex_valid = 1; ex_wr_rd = 1; ex_rd = 6;
    mem_valid = 1; mem_wr_rd = 1; mem_rd = 5;
    cycle("fw mem", C_RUN_I, RUN);
    chk("fw mem fwd_a", 32'(fwd_a), 32'd2);
    // Both stages write r5: nearest wins, on both operands.
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; id_use_rs2 = 1; id_rs2 = 5;
    ex_valid = 1; ex_wr_rd = 1; ex_rd = 5; mem_valid = 1; mem_wr_rd = 1; mem_rd = 5;
    cycle("fw near", C_RUN_I, RUN);
    chk("fw near fwd_a", 32'(fwd_a), 32'd1);
    chk("fw near fwd_b", 32'(fwd_b), 32'd1);
    // Load-use: one stall with a bubble, then MEM_WB forwarding.
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    ex_valid = 1; ex_wr_rd = 1; ex_is_load = 1; ex_rd = 5;
    cycle("ld hz", C_HZ, HAZARD);
    chk("ld hz fwd_a", 32'(fwd_a), 32'd0);
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; mem_valid = 1; mem_wr_rd = 1; mem_rd = 5;
    cycle("ld issue", C_RUN_I, RUN);
    chk("ld issue fwd_a", 32'(fwd_a), 32'd2);
    // Memory wait holds the select, then the ack cycle loads the new one.
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; ex_valid = 1; ex_wr_rd = 1; ex_rd = 5;
    mem_req = 1;
    cycle("fw mw", C_MW, MEMWAIT);
    chk("fw mw fwd_a", 32'(fwd_a), 32'd2);
    mem_ack = 1;
    cycle("fw ack", C_RUN_I, RUN);
    chk("fw ack fwd_a", 32'(fwd_a), 32'd1);
    // Load in EX to an unused register: no stall.
    clr(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 6;
    ex_valid = 1; ex_wr_rd = 1; ex_is_load = 1; ex_rd = 5;
    cycle("ld other", C_RUN_I, RUN);
    chk("ld other fwd_a", 32'(fwd_a), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
